// File: rtl/div_recon_pkg.sv
// Shared types and helpers for the divider reconstruction checker.
package div_recon_pkg;

    localparam int W_D_DEF   = 8;
    localparam int W_N_DEF   = 16;
    localparam int ACC_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ADD,
        DONE
    } state_e;

    // Adds inc to a, clamping at the all-ones value of a w-bit counter (w <= 32).
    function automatic logic [63:0] sat_inc(
        input logic [63:0] a,
        input logic [63:0] inc,
        input int unsigned w
    );
        logic [63:0] lim;
        logic [63:0] s;
        lim = (64'd1 << w) - 64'd1;
        s   = a + inc;
        return (s > lim) ? lim : s;
    endfunction

endpackage

// File: rtl/div_recon_stats.sv
// Running error statistics; a clear coinciding with a result is applied first.
module div_recon_stats
    import div_recon_pkg::*;
#(
    parameter int W_N   = W_N_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             hs,
    input  logic [W_N-1:0]   err,
    input  logic             exact,
    output logic [ACC_W-1:0] count,
    output logic [ACC_W-1:0] err_sum,
    output logic [W_N-1:0]   err_max,
    output logic [ACC_W-1:0] inexact
);

    logic [ACC_W-1:0] count_q, count_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [W_N-1:0]   max_q, max_d;
    logic [ACC_W-1:0] inex_q, inex_d;

    always_comb begin
        count_d = clr ? '0 : count_q;
        sum_d   = clr ? '0 : sum_q;
        max_d   = clr ? '0 : max_q;
        inex_d  = clr ? '0 : inex_q;
        if (hs) begin
            count_d = ACC_W'(sat_inc(64'(count_d), 64'd1, ACC_W));
            sum_d   = ACC_W'(sat_inc(64'(sum_d), 64'(err), ACC_W));
            if (err > max_d) begin
                max_d = err;
            end
            if (!exact) begin
                inex_d = ACC_W'(sat_inc(64'(inex_d), 64'd1, ACC_W));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            sum_q   <= '0;
            max_q   <= '0;
            inex_q  <= '0;
        end else begin
            count_q <= count_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
            inex_q  <= inex_d;
        end
    end

    assign count   = count_q;
    assign err_sum = sum_q;
    assign err_max = max_q;
    assign inexact = inex_q;

endmodule

// File: rtl/div_recon_checker.sv
// Rebuilds n_hat = q*d + r with a bit-serial shift-add and reports the error.
module div_recon_checker
    import div_recon_pkg::*;
#(
    parameter int W_D   = W_D_DEF,
    parameter int W_N   = W_N_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_N-1:0]   in_n,
    input  logic [W_D-1:0]   in_d,
    input  logic [W_D-1:0]   in_q,
    input  logic [W_D-1:0]   in_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_N-1:0]   out_n_hat,
    output logic [W_N-1:0]   out_err,
    output logic             out_exact,
    input  logic             stat_clr,
    output logic [ACC_W-1:0] stat_count,
    output logic [ACC_W-1:0] stat_err_sum,
    output logic [W_N-1:0]   stat_err_max,
    output logic [ACC_W-1:0] stat_inexact
);

    localparam int IW = $clog2(W_D);

    state_e         state_q, state_d;
    logic [W_N-1:0] n_q, n_d;
    logic [W_D-1:0] d_q, d_d;
    logic [W_D-1:0] q_q, q_d;
    logic [W_D-1:0] r_q, r_d;
    logic [W_N-1:0] acc_q, acc_d;
    logic [IW-1:0]  i_q, i_d;
    logic [W_N-1:0] n_hat_q, n_hat_d;
    logic [W_N-1:0] err_q, err_d;
    logic           exact_q, exact_d;
    logic [W_N-1:0] n_hat_c;
    logic           hs;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        d_d     = d_q;
        q_d     = q_q;
        r_d     = r_q;
        acc_d   = acc_q;
        i_d     = i_q;
        n_hat_d = n_hat_q;
        err_d   = err_q;
        exact_d = exact_q;
        n_hat_c = acc_q + W_N'(r_q);
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    n_d     = in_n;
                    d_d     = in_d;
                    q_d     = in_q;
                    r_d     = in_r;
                    acc_d   = '0;
                    i_d     = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                if (q_q[i_q]) begin
                    acc_d = acc_q + (W_N'(d_q) << i_q);
                end
                i_d = i_q + IW'(1);
                if (i_q == IW'(W_D - 1)) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                n_hat_d = n_hat_c;
                err_d   = (n_q >= n_hat_c) ? n_q - n_hat_c : n_hat_c - n_q;
                exact_d = (n_hat_c == n_q) && (r_q < d_q);
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= '0;
            d_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            n_hat_q <= '0;
            err_q   <= '0;
            exact_q <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            d_q     <= d_d;
            q_q     <= q_d;
            r_q     <= r_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            n_hat_q <= n_hat_d;
            err_q   <= err_d;
            exact_q <= exact_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_n_hat = n_hat_q;
    assign out_err   = err_q;
    assign out_exact = exact_q;
    assign hs        = out_valid && out_ready;

    div_recon_stats #(
        .W_N   (W_N),
        .ACC_W (ACC_W)
    ) u_stats (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (stat_clr),
        .hs      (hs),
        .err     (err_q),
        .exact   (exact_q),
        .count   (stat_count),
        .err_sum (stat_err_sum),
        .err_max (stat_err_max),
        .inexact (stat_inexact)
    );

endmodule

// File: tb/tb_div_recon_checker.sv
// Directed-vector bench for div_recon_checker.
module tb_div_recon_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_n;
    logic [7:0]  in_d;
    logic [7:0]  in_q;
    logic [7:0]  in_r;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_n_hat;
    logic [15:0] out_err;
    logic        out_exact;
    logic        stat_clr;
    logic [31:0] stat_count;
    logic [31:0] stat_err_sum;
    logic [15:0] stat_err_max;
    logic [31:0] stat_inexact;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    div_recon_checker dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_n         (in_n),
        .in_d         (in_d),
        .in_q         (in_q),
        .in_r         (in_r),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_n_hat    (out_n_hat),
        .out_err      (out_err),
        .out_exact    (out_exact),
        .stat_clr     (stat_clr),
        .stat_count   (stat_count),
        .stat_err_sum (stat_err_sum),
        .stat_err_max (stat_err_max),
        .stat_inexact (stat_inexact)
    );

    task automatic send(input logic [15:0] n, input logic [7:0] d,
                        input logic [7:0] q, input logic [7:0] r);
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1)
            $display("FAIL send_ready got=%b want=1", in_ready);
        else pass_cnt++;
        in_valid = 1'b1;
        in_n = n; in_d = d; in_q = q; in_r = r;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Returns the cycle (counted from the accept cycle as 0) where out_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic accept(input logic clr);
        @(negedge clk);
        out_ready = 1'b1;
        stat_clr = clr;
        @(posedge clk);
        #1 out_ready = 1'b0;
        stat_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_hs ready=%b valid=%b want 1/0", in_ready, out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_n_hat !== 16'd0 || out_err !== 16'd0 || out_exact !== 1'b0)
            $display("FAIL reset_out n_hat=%0d err=%0d exact=%b want 0", out_n_hat, out_err, out_exact);
        else pass_cnt++;
        total_cnt++;
        if (stat_count !== 0 || stat_err_sum !== 0 || stat_err_max !== 0 || stat_inexact !== 0)
            $display("FAIL reset_stats cnt=%0d sum=%0d max=%0d inex=%0d want 0",
                     stat_count, stat_err_sum, stat_err_max, stat_inexact);
        else pass_cnt++;
    endtask

    task automatic check_result(input string name, input logic [15:0] nh,
                                input logic [15:0] e, input logic ex);
        int lat;
        wait_result(lat);
        total_cnt++;
        if (lat !== 10) $display("FAIL %s_latency got=%0d want=10", name, lat);
        else pass_cnt++;
        total_cnt++;
        if (out_n_hat !== nh || out_err !== e || out_exact !== ex)
            $display("FAIL %s_out n_hat=%0d err=%0d exact=%b want %0d/%0d/%b",
                     name, out_n_hat, out_err, out_exact, nh, e, ex);
        else pass_cnt++;
    endtask

    task automatic check_stats(input string name, input int c, input int s,
                               input int m, input int x);
        total_cnt++;
        if (stat_count !== c || stat_err_sum !== s || stat_err_max !== m || stat_inexact !== x)
            $display("FAIL %s_stats cnt=%0d sum=%0d max=%0d inex=%0d want %0d/%0d/%0d/%0d",
                     name, stat_count, stat_err_sum, stat_err_max, stat_inexact, c, s, m, x);
        else pass_cnt++;
    endtask

    task automatic test_exact;
        send(16'd1000, 8'd7, 8'd142, 8'd6);
        check_result("exact", 16'd1000, 16'd0, 1'b1);
        accept(1'b0);
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL exact_ready ready=%b valid=%b want 1/0", in_ready, out_valid);
        else pass_cnt++;
        check_stats("exact", 1, 0, 0, 0);
    endtask

    task automatic test_inexact;
        send(16'd1000, 8'd7, 8'd140, 8'd6);
        check_result("inexact", 16'd986, 16'd14, 1'b0);
        accept(1'b0);
        check_stats("inexact", 2, 14, 14, 1);
    endtask

    task automatic test_extremes;
        send(16'd0, 8'd255, 8'd255, 8'd255);
        check_result("max", 16'd65280, 16'd65280, 1'b0);
        accept(1'b0);
        check_stats("max", 3, 65294, 65280, 2);
        send(16'd3, 8'd0, 8'd9, 8'd3);
        check_result("div0", 16'd3, 16'd0, 1'b0);
        accept(1'b0);
        check_stats("div0", 4, 65294, 65280, 3);
    endtask

    task automatic test_backpressure;
        int lat;
        send(16'd1000, 8'd7, 8'd142, 8'd6);
        wait_result(lat);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_n = 16'(k * 4099 + 17);
            in_d = 8'(k + 3);
            in_q = 8'(k * 37);
            in_r = 8'(k * 11);
            @(negedge clk);
            total_cnt++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_n_hat !== 16'd1000 ||
                out_err !== 16'd0 || out_exact !== 1'b1)
                $display("FAIL bp_hold%0d valid=%b ready=%b n_hat=%0d err=%0d exact=%b want 1/0/1000/0/1",
                         k, out_valid, in_ready, out_n_hat, out_err, out_exact);
            else pass_cnt++;
            total_cnt++;
            if (stat_count !== 32'd4)
                $display("FAIL bp_stats%0d cnt=%0d want=4", k, stat_count);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        accept(1'b0);
        check_stats("bp", 5, 65294, 65280, 3);
    endtask

    task automatic test_reset_mid;
        bit seen = 1'b0;
        send(16'd1000, 8'd7, 8'd140, 8'd6);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL rstmid_ready ready=%b valid=%b want 1/0", in_ready, out_valid);
        else pass_cnt++;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        total_cnt++;
        if (seen) $display("FAIL rstmid_valid got=1 want=0");
        else pass_cnt++;
        check_stats("rstmid", 0, 0, 0, 0);
    endtask

    task automatic test_clr_handshake;
        send(16'd989, 8'd7, 8'd140, 8'd6);
        check_result("pre", 16'd986, 16'd3, 1'b0);
        accept(1'b0);
        check_stats("pre", 1, 3, 3, 1);
        send(16'd991, 8'd7, 8'd140, 8'd6);
        check_result("clrhs", 16'd986, 16'd5, 1'b0);
        accept(1'b1);
        check_stats("clrhs", 1, 5, 5, 1);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        check_stats("clr", 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_n = '0; in_d = '0; in_q = '0; in_r = '0;
        out_ready = 1'b0;
        stat_clr = 1'b0;
        test_reset();
        test_exact();
        test_inexact();
        test_extremes();
        test_backpressure();
        test_reset_mid();
        test_clr_handshake();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/div_recon_checker.md
# div_recon_checker

Sequential reconstruction checker for the 16/8 array dividers, approximate and exact. It takes a dividend, the divisor, and the quotient and remainder a divider produced. It rebuilds n_hat = q*d + r with an 8-cycle shift-add multiplier and reports |n − n_hat| and an exactness flag. It also keeps running error statistics, so approximate divider variants can be characterised in simulation or on FPGA without a golden model.

## Interface
Parameters:
- W_D, 8, divisor, quotient and remainder width
- W_N, 16, dividend and reconstruction width (2*W_D)
- ACC_W, 32, statistics counter width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand tuple valid
- in_ready  out  1  block can accept a tuple; high only in IDLE
- in_n  in  W_N  original dividend
- in_d  in  W_D  divisor
- in_q  in  W_D  quotient under test
- in_r  in  W_D  remainder under test
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  consumer accepts the result
- out_n_hat  out  W_N  q*d + r
- out_err  out  W_N  |in_n − n_hat|
- out_exact  out  1  high when n_hat == in_n and in_r < in_d
- stat_clr  in  1  synchronous clear of the statistics
- stat_count  out  ACC_W  number of completed results
- stat_err_sum  out  ACC_W  sum of out_err
- stat_err_max  out  W_N  maximum out_err seen
- stat_inexact  out  ACC_W  number of results with out_exact = 0

## Operation
- FSM states: IDLE → MUL → ADD → DONE → IDLE.
- IDLE
  - in_ready = 1.
  - On in_valid & in_ready, latch n, d, q, r, clear the accumulator, set bit index i = 0, go to MUL.
- MUL, 8 cycles, LSB first
  - If q[i] = 1: acc += zero-extend(d) << i.
  - Then i++. After i = 7, go to ADD.
  - Latency is fixed; there is no early exit on q = 0.
- ADD, 1 cycle
  - n_hat = acc + r. The maximum is 255*255 + 255 = 65280, so no overflow occurs in W_N bits.
  - err = (n ≥ n_hat) ? n − n_hat : n_hat − n.
  - exact = (n_hat == n) && (r < d).
  - Register all three, go to DONE.
- DONE
  - out_valid = 1; outputs hold stable while out_ready = 0.
  - On out_valid & out_ready, go to IDLE and update the statistics:
    - count++
    - err_sum += err
    - err_max = max(err_max, err)
    - inexact++ if !exact
- Divisor zero (d = 0): computed normally; n_hat = r, exact = 0 because r < 0 is false.
- Saturation: stat_count, stat_err_sum and stat_inexact saturate at all-ones and never wrap.
- stat_clr
  - Zeroes all four statistics.
  - If it coincides with an output handshake, the clear applies first and that result is then included, so count = 1 afterwards.
- Latched operands are held from acceptance until the DONE handshake. in_* changes during MUL, ADD or DONE have no effect.

## Timing
- Cycle 0: input handshake. Cycles 1–8: MUL. Cycle 9: ADD. out_valid rises at the edge ending cycle 9 and is visible in cycle 10.
- Accept-to-result latency is 10 cycles.
- Maximum throughput is one tuple per 11 cycles with out_ready tied high. in_ready returns to 1 in the cycle after the output handshake.
- Reset (rst_n = 0 at a clock edge):
  - State goes to IDLE.
  - out_valid = 0, out_n_hat = 0, out_err = 0, out_exact = 0.
  - All statistics = 0.
  - in_ready = 1 in the first cycle after reset is released.
- Reset mid-MUL or mid-DONE aborts the transaction with no statistics update and no output.
- out_* are registered. No combinational path runs from in_* or out_ready to any output except in_ready, which is decoded from the state register.

## Structure
- Package div_recon_pkg holds:
  - the state enum {IDLE, MUL, ADD, DONE}
  - the W_D, W_N and ACC_W defaults
  - the saturating-increment function
- Sub-module div_recon_stats contains the statistics accumulators, stat_clr priority and saturation. Its inputs are the handshake strobe, err and exact.
- The top level holds the FSM, operand latches and shift-add datapath.

## Test plan
- n=1000, d=7, q=142, r=6 → out_n_hat=1000, out_err=0, out_exact=1, out_valid in cycle 10 after accept.
- n=1000, d=7, q=140, r=6 → out_n_hat=986, out_err=14, out_exact=0; after the handshake stat_inexact=1 and stat_err_max=14.
- n=0, d=255, q=255, r=255 → out_n_hat=65280, out_err=65280; also d=0, q=9, r=3, n=3 → n_hat=3, err=0, exact=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and new in_* toggling.
  - Required: outputs stable, in_ready=0, no stats change; accepted on the 6th cycle.
- Reset at MUL cycle 4: rst_n low 1 cycle → out_valid stays 0, stats remain 0, in_ready=1 the next cycle.
- stat_clr asserted in the same cycle as a handshake with err=5 → stat_count=1, stat_err_sum=5, stat_err_max=5.
